acc_result_collector: RTL

- Sits directly downstream of SYSTOLIC_DF and captures every valid accumulator result (acc_out_i/acc_out_valid_i) into an internal FIFO.
- Exposes the FIFO and its status to the management CPU as a Wishbone slave register window.
- Counts received results against a CPU-programmed expected count and raises an interrupt when the full result set has arrived.
- Lets firmware drain systolic results without polling DRAM.

---
 rtl/acc_result_collector.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/acc_result_collector.sv
// acc_result_collector
//   Captures accumulator results from the systolic array into a FIFO and
//   exposes them, plus status/control, as a Wishbone slave register window.
//   Raises a level interrupt once RECEIVED reaches the programmed EXPECTED.
//
// Ports
//   wb_clk_i, wb_rst_n           clock, async active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i   Wishbone slave request
//   wbs_adr_i, wbs_dat_i         byte address, write data
//   wbs_ack_o, wbs_dat_o         registered acknowledge, read data
//   func_sel_i                   results accepted only when 1
//   acc_out_i, acc_out_valid_i   systolic result stream
//   irq_o                        DONE interrupt (level)
//
// Registers (offset = adr[3:2])
//   0x0 RESULT   RO  read pops FIFO head
//   0x4 STATUS   RO  [15:0] count [16] empty [17] full [18] OVF [19] UNF [20] DONE
//   0x8 CTRL     RW  [15:0] EXPECTED, [31] CLEAR (self-clearing)
//   0xC RECEIVED RO  [15:0]
module acc_result_collector #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_8000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic                  func_sel_i,
  input  logic [DATA_WIDTH-1:0] acc_out_i,
  input  logic                  acc_out_valid_i,
  output logic                  irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    REG_RESULT   = 2'd0,
    REG_STATUS   = 2'd1,
    REG_CTRL     = 2'd2,
    REG_RECEIVED = 2'd3
  } reg_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [15:0]           received;
  logic [15:0]           expected;
  logic                  ovf;
  logic                  unf;
  logic                  done;

  logic        hit;
  logic        rd_hit;
  logic        wr_hit;
  reg_e        reg_sel;
  logic        full;
  logic        empty;
  logic        push;
  logic        push_ok;
  logic        drop;
  logic        pop;
  logic        underflow;
  logic        clear;
  logic        ctrl_wr;
  logic [15:0] exp_next;
  logic [15:0] recv_next;
  logic        done_next;
  logic [31:0] rd_data;

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[30:16], wbs_sel_i[2]};

  always_comb begin
    hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~wbs_ack_o;
    rd_hit    = hit & ~wbs_we_i;
    wr_hit    = hit & wbs_we_i;
    reg_sel   = reg_e'(wbs_adr_i[3:2]);
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    push      = acc_out_valid_i & func_sel_i;
    pop       = rd_hit & (reg_sel == REG_RESULT) & ~empty;
    underflow = rd_hit & (reg_sel == REG_RESULT) & empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push_ok   = push & (~full | pop);
    drop      = push & full & ~pop;
    clear     = wr_hit & (reg_sel == REG_CTRL) & wbs_sel_i[3] & wbs_dat_i[31];
    ctrl_wr   = wr_hit & (reg_sel == REG_CTRL) & (|wbs_sel_i[1:0]);
  end

  always_comb begin
    exp_next = expected;
    if (ctrl_wr & wbs_sel_i[0]) exp_next[7:0]  = wbs_dat_i[7:0];
    if (ctrl_wr & wbs_sel_i[1]) exp_next[15:8] = wbs_dat_i[15:8];

    recv_next = push ? received + 16'd1 : received;

    done_next = ctrl_wr ? 1'b0 : done;
    if (push && (recv_next == exp_next) && (exp_next != '0)) done_next = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    unique case (reg_sel)
      REG_RESULT:   rd_data = empty ? '0 : 32'(mem[rd_ptr]);
      REG_STATUS:   rd_data = {11'd0, done, unf, ovf, full, empty, 16'(count)};
      REG_CTRL:     rd_data = {16'd0, expected};
      REG_RECEIVED: rd_data = {16'd0, received};
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      received  <= '0;
      expected  <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= rd_hit ? rd_data : '0;
      expected  <= exp_next;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        received <= '0;
        ovf      <= 1'b0;
        unf      <= 1'b0;
        done     <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        count    <= count + CW'(push_ok) - CW'(pop);
        received <= recv_next;
        done     <= done_next;
        if (drop)      ovf <= 1'b1;
        if (underflow) unf <= 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok && !clear) mem[wr_ptr] <= acc_out_i;
  end

  assign irq_o = done;

endmodule
